// File: rtl/dmem_store_buffer_pkg.sv
// Shared data-memory widths and store-buffer types.
// Imported by the store buffer and its forwarding comparator.
package dmem_store_buffer_pkg;

    localparam int DMEM_ADDR_W      = 12;
    localparam int WORD_W           = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    // Owner of the single RAM port in a given cycle.
    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_op_e;

endpackage

// File: rtl/dmem_store_buffer_fwd.sv
// Age-priority address comparator for store-to-load forwarding.
// Reports the youngest live entry whose address equals the probe.
module sb_forward_match
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [PTR_W-1:0]             i_head,
    input  logic [CNT_W-1:0]             i_count,
    input  logic [ADDR_W-1:0]            i_probe,
    output logic                         o_hit,
    output logic [PTR_W-1:0]             o_hit_idx
);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if ((CNT_W'(k) < i_count) && i_valid[w_idx] &&
                (i_addr[w_idx] == i_probe)) begin
                o_hit     = 1'b1;
                o_hit_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the M stage and the single-port data RAM.
// Loads own the port; stores drain on idle cycles with forwarding.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEFAULT,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               cpu_addr,
    input  logic [DATA_W-1:0]         cpu_data,
    input  logic                      cpu_wren,
    input  logic                      cpu_rden,
    output logic [DATA_W-1:0]         cpu_q,
    output logic                      buf_full,
    output logic                      buf_empty,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_d,
    output logic                      mem_wren,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]             r_head;
    logic [PTR_W-1:0]             r_tail;
    logic [CNT_W-1:0]             r_count;
    logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][DATA_W-1:0] r_data;
    logic [DEPTH-1:0]             r_valid;

    logic [ADDR_W-1:0]            w_probe;
    logic                         w_unused_addr;
    port_op_e                     w_op;
    logic                         w_drain;
    logic                         w_accept;
    logic                         w_hit;
    logic [PTR_W-1:0]             w_hit_idx;

    assign w_probe       = cpu_addr[ADDR_W-1:0];
    assign w_unused_addr = ^cpu_addr[31:ADDR_W];

    // Port arbitration: a load always wins, otherwise drain if anything queued.
    always_comb begin
        if (cpu_rden) begin
            w_op = PORT_LOAD;
        end else if (r_count != '0) begin
            w_op = PORT_DRAIN;
        end else begin
            w_op = PORT_IDLE;
        end
    end

    assign w_drain  = (w_op == PORT_DRAIN);
    assign w_accept = cpu_wren & ((r_count != FULL_CNT) | w_drain);
    assign buf_full = cpu_wren & (r_count == FULL_CNT) & ~w_drain;

    assign buf_empty = (r_count == '0);
    assign occupancy = r_count;

    // RAM port mux driven by the arbitration decision.
    always_comb begin
        mem_addr = '0;
        mem_d    = '0;
        mem_wren = 1'b0;
        case (w_op)
            PORT_LOAD: begin
                mem_addr = w_probe;
            end
            PORT_DRAIN: begin
                mem_addr = r_addr[r_head];
                mem_d    = r_data[r_head];
                mem_wren = 1'b1;
            end
            default: begin
                mem_addr = '0;
            end
        endcase
    end

    sb_forward_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fwd (
        .i_addr    (r_addr),
        .i_valid   (r_valid),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_probe   (w_probe),
        .o_hit     (w_hit),
        .o_hit_idx (w_hit_idx)
    );

    assign cpu_q = w_hit ? r_data[w_hit_idx] : mem_q;

    // FIFO state; retire at head before filling tail so a full-queue
    // drain-and-accept on the same slot leaves it valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            if (w_drain) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= w_probe;
                r_data[r_tail]  <= cpu_data;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_accept && !w_drain) begin
                r_count <= r_count + 1'b1;
            end else if (w_drain && !w_accept) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer.
// Expected RAM writes are queued at drive time, popped on mem_wren.
module tb_dmem_store_buffer;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic        cpu_rden;
    logic [31:0] cpu_q;
    logic        buf_full;
    logic        buf_empty;
    logic [2:0]  occupancy;
    logic [11:0] mem_addr;
    logic [31:0] mem_d;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] ram [0:4095];
    logic [43:0] sb_q [$];
    int          n_checks;
    int          n_errors;

    dmem_store_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_wren  (cpu_wren),
        .cpu_rden  (cpu_rden),
        .cpu_q     (cpu_q),
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .occupancy (occupancy),
        .mem_addr  (mem_addr),
        .mem_d     (mem_d),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_q = ram[mem_addr];

    always @(negedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_d;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Every RAM write must be the oldest outstanding expected store.
    always @(negedge clock) begin
        logic [43:0] e;
        if (cpu_wren && cpu_rden)
            $display("note: wren+rden together at %0t, treated as store", $time);
        if (reset && mem_wren) begin
            if (sb_q.size() == 0) begin
                chk("unexp_wr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_addr", 32'(mem_addr), 32'(e[43:32]));
                chk("sb_data", mem_d, e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        cpu_wren = w;
        cpu_rden = r;
        cpu_addr = a;
        cpu_data = d;
        if (w) sb_q.push_back({a[11:0], d});
    endtask

    task automatic wait_empty(input string tag);
        for (int k = 0; k < 20 && !buf_empty; k++) cyc();
        chk(tag, 32'(buf_empty), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) ram[i] <= 32'h0;
        ram[8] <= 32'h99;
        reset    = 1'b0;
        cpu_wren = 1'b0;
        cpu_rden = 1'b0;
        cpu_addr = 32'h0;
        cpu_data = 32'h0;

        // 1: reset and idle
        repeat (2) begin
            @(negedge clock);
            chk("rst_empty", 32'(buf_empty), 32'd1);
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_wren", 32'(mem_wren), 32'd0);
        end
        cyc();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("idle_empty", 32'(buf_empty), 32'd1);
            chk("idle_wren", 32'(mem_wren), 32'd0);
            cyc();
        end

        // 2: single store, drained the cycle after
        drive(1'b1, 1'b0, 32'd5, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("st_no_wt", 32'(mem_wren), 32'd0);
        chk("st_nofull", 32'(buf_full), 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        chk("dr_wren", 32'(mem_wren), 32'd1);
        chk("dr_addr", 32'(mem_addr), 32'd5);
        chk("dr_data", mem_d, 32'hDEAD_BEEF);
        cyc();
        chk("dr_empty", 32'(buf_empty), 32'd1);

        // 3: youngest-entry forwarding
        drive(1'b1, 1'b1, 32'd7, 32'h11);
        cyc();
        drive(1'b1, 1'b1, 32'd7, 32'h22);
        cyc();
        drive(1'b0, 1'b1, 32'd7, 32'h0);
        @(negedge clock);
        chk("fw_young", cpu_q, 32'h22);
        chk("fw_occ", 32'(occupancy), 32'd2);
        chk("fw_nodrain", 32'(mem_wren), 32'd0);
        cyc();
        drive(1'b0, 1'b1, 32'd8, 32'h0);
        @(negedge clock);
        chk("fw_miss", cpu_q, 32'h99);
        cyc();
        drive(1'b0, 1'b1, 32'hABCD_E007, 32'h0);
        @(negedge clock);
        chk("fw_trunc", cpu_q, 32'h22);
        cyc();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        wait_empty("fw_drain");
        drive(1'b0, 1'b1, 32'd7, 32'h0);
        @(negedge clock);
        chk("ld_ram", cpu_q, 32'h22);
        cyc();

        // 4: full and stall, then drain-and-accept
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h10 + 32'(i), 32'h100 + 32'(i));
            cyc();
        end
        drive(1'b1, 1'b1, 32'h14, 32'h104);
        @(negedge clock);
        chk("full_flag", 32'(buf_full), 32'd1);
        chk("full_occ", 32'(occupancy), 32'd4);
        cyc();
        @(negedge clock);
        chk("hold_occ", 32'(occupancy), 32'd4);
        chk("hold_full", 32'(buf_full), 32'd1);
        cyc();
        cpu_rden = 1'b0;
        @(negedge clock);
        chk("acc_full", 32'(buf_full), 32'd0);
        chk("acc_wren", 32'(mem_wren), 32'd1);
        chk("acc_addr", 32'(mem_addr), 32'h10);
        cyc();
        cpu_wren = 1'b0;
        chk("acc_occ", 32'(occupancy), 32'd4);
        wait_empty("full_drain");

        // 5: wrap-around with interleaved idles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'hA000 + 32'(i));
            cyc();
            if (i % 2 == 1) begin
                drive(1'b0, 1'b0, 32'd0, 32'd0);
                cyc();
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        wait_empty("wrap_drain");
        chk("wrap_occ", 32'(occupancy), 32'd0);
        for (int i = 0; i < 10; i++) chk("wrap_ram", ram[i], 32'hA000 + 32'(i));

        // 6: reset asserted mid-drain discards the rest
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h20 + 32'(i), 32'hC0 + 32'(i));
            cyc();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_wren", 32'(mem_wren), 32'd0);
        chk("mrst_occ", 32'(occupancy), 32'd0);
        sb_q.delete();
        cyc();
        reset = 1'b1;
        repeat (5) cyc();
        chk("mrst_occ2", 32'(occupancy), 32'd0);
        chk("mrst_ram1", ram[12'h21], 32'h0);
        chk("mrst_ram2", ram[12'h22], 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
